// File: rtl/sample_collect_sched_if.sv
// Bus bundle for sample_collect_sched: EBI config bus, pin-controller poll handshake
// and sample-RAM write port. master = scheduler side, slave = environment side.
interface sample_collect_sched_if #(
  parameter int MEM_AW = 15
);
  logic [18:0]       ebi_addr;
  logic [15:0]       ebi_data_in;
  logic [15:0]       ebi_data_out;
  logic              ebi_enable;
  logic              ebi_rd;
  logic              ebi_wr;
  logic [15:0]       unit_sel;
  logic              unit_req;
  logic              unit_ack;
  logic              unit_has_sample;
  logic [15:0]       unit_data;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              busy;

  modport master (
    input  ebi_addr, ebi_data_in, ebi_enable, ebi_rd, ebi_wr,
    input  unit_ack, unit_has_sample, unit_data,
    output ebi_data_out, unit_sel, unit_req, mem_we, mem_addr, mem_wdata, busy
  );

  modport slave (
    output ebi_addr, ebi_data_in, ebi_enable, ebi_rd, ebi_wr,
    output unit_ack, unit_has_sample, unit_data,
    input  ebi_data_out, unit_sel, unit_req, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/sample_collect_sched.sv
// Round-robin sample collector: polls a programmable table of pin-controller units and
// streams returned samples into a circular sample RAM. Option macro: SAMPLE_TIMESTAMP_EN.
module sample_collect_sched #(
  parameter int POSITION  = 0,
  parameter int NUM_UNITS = 10,
  parameter int MEM_AW    = 15,
  parameter int TIMEOUT   = 255
) (
  input logic                    clk,
  input logic                    rst,
  sample_collect_sched_if.master bus
);

  localparam int NW = $clog2(NUM_UNITS + 1);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT_ACK, WRITE_TS, WRITE, NEXT} state_t;

  state_t            state;
  logic [15:0]       tbl [NUM_UNITS];
  logic [NW-1:0]     num_units;
  logic              run;
  logic [NW-1:0]     idx;
  logic [CW-1:0]     wcnt;
  logic [MEM_AW-1:0] wr_ptr;
  logic              overflow;
  logic [7:0]        tmo_cnt;

  logic              sel;
  logic              clr;
  logic [15:0]       rdata;
  logic [15:0]       sel_entry;
  logic [NW:0]       idx_inc;
  logic [NW-1:0]     next_idx;

  assign sel = bus.ebi_enable && (bus.ebi_addr[18:8] == 11'(POSITION));
  assign clr = sel && bus.ebi_wr && (bus.ebi_addr[7:0] == 8'h21) && bus.ebi_data_in[1];

  assign idx_inc  = {1'b0, idx} + 1'b1;
  assign next_idx = (idx_inc >= {1'b0, num_units}) ? '0 : idx_inc[NW-1:0];

`ifdef SAMPLE_TIMESTAMP_EN
  logic [15:0] ts;
  logic [15:0] data_lat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     ts <= '0;
    else if (clr) ts <= '0;
    else          ts <= ts + 1'b1;
  end
`endif

  always_comb begin
    sel_entry = '0;
    for (int unsigned i = 0; i < NUM_UNITS; i++)
      if (idx == NW'(i)) sel_entry = tbl[i];
  end

  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < NUM_UNITS; i++)
      if (bus.ebi_addr[7:0] == 8'(i)) rdata = tbl[i];
    case (bus.ebi_addr[7:0])
      8'h20:   rdata = 16'(num_units);
      8'h21:   rdata = {15'b0, run};
      8'h22:   rdata = {tmo_cnt, 6'b0, overflow, bus.busy};
      8'h23:   rdata = 16'(wr_ptr);
`ifdef SAMPLE_TIMESTAMP_EN
      8'h24:   rdata = ts;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_UNITS; i++) tbl[i] <= '0;
      num_units        <= '0;
      run              <= 1'b0;
      bus.ebi_data_out <= '0;
    end else begin
      if (sel && bus.ebi_wr) begin
        for (int unsigned i = 0; i < NUM_UNITS; i++)
          if (bus.ebi_addr[7:0] == 8'(i)) tbl[i] <= bus.ebi_data_in;
        if (bus.ebi_addr[7:0] == 8'h20) begin
          if (bus.ebi_data_in > 16'(NUM_UNITS)) num_units <= NW'(NUM_UNITS);
          else                                  num_units <= bus.ebi_data_in[NW-1:0];
        end
        if (bus.ebi_addr[7:0] == 8'h21) run <= bus.ebi_data_in[0];
      end
      if (sel && bus.ebi_rd) bus.ebi_data_out <= rdata;
    end
  end

  // Outputs are set on the edge entering a state so that unit_req is high exactly
  // during WAIT_ACK and mem_we exactly during the write state(s).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      idx           <= '0;
      wcnt          <= '0;
      wr_ptr        <= '0;
      overflow      <= 1'b0;
      tmo_cnt       <= '0;
      bus.unit_sel  <= '0;
      bus.unit_req  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.busy      <= 1'b0;
`ifdef SAMPLE_TIMESTAMP_EN
      data_lat      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (run && (num_units != '0)) begin
            state    <= REQ;
            bus.busy <= 1'b1;
          end
        end
        REQ: begin
          bus.unit_sel <= sel_entry;
          bus.unit_req <= 1'b1;
          wcnt         <= '0;
          state        <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (bus.unit_ack) begin
            bus.unit_req <= 1'b0;
            if (bus.unit_has_sample) begin
              bus.mem_we   <= 1'b1;
              bus.mem_addr <= wr_ptr;
`ifdef SAMPLE_TIMESTAMP_EN
              bus.mem_wdata <= ts;
              data_lat      <= bus.unit_data;
              state         <= WRITE_TS;
`else
              bus.mem_wdata <= bus.unit_data;
              state         <= WRITE;
`endif
            end else begin
              state <= NEXT;
            end
          end else if (wcnt == CW'(TIMEOUT - 1)) begin
            bus.unit_req <= 1'b0;
            if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + 1'b1;
            state <= NEXT;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        WRITE_TS: begin
`ifdef SAMPLE_TIMESTAMP_EN
          bus.mem_addr  <= wr_ptr + 1'b1;
          bus.mem_wdata <= data_lat;
          wr_ptr        <= wr_ptr + 1'b1;
          if (&wr_ptr) overflow <= 1'b1;
          state <= WRITE;
`else
          state <= NEXT;
`endif
        end
        WRITE: begin
          bus.mem_we <= 1'b0;
          wr_ptr     <= wr_ptr + 1'b1;
          if (&wr_ptr) overflow <= 1'b1;
          state <= NEXT;
        end
        NEXT: begin
          idx <= next_idx;
          if (run && (num_units != '0)) begin
            state <= REQ;
          end else begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      // Clear overrides any same-cycle pointer/counter update; mem_addr already holds the old pointer.
      if (clr) begin
        wr_ptr   <= '0;
        overflow <= 1'b0;
        tmo_cnt  <= '0;
        idx      <= '0;
      end
    end
  end

endmodule
